// File: rtl/logic_op_pkg.sv
// Shared op encodings and the bitwise op evaluator for the logic_op_pipe datapath.
package logic_op_pkg;

  // Widest operand apply_op can evaluate; callers zero-extend and slice back to their width.
  localparam int unsigned OP_MAX_W = 64;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_t;

  function automatic logic [OP_MAX_W-1:0] apply_op(
    input op_t                 op,
    input logic [OP_MAX_W-1:0] x,
    input logic [OP_MAX_W-1:0] y
  );
    logic [OP_MAX_W-1:0] r;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      default: r = ~(x & y);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_stage.sv
// One pipeline stage: a valid bit plus a data word, loaded when the stage advances.
module logic_op_stage
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             adv,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid_nxt,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next state: flush clears the valid bit, otherwise load from upstream on advance, else hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = src_valid;
      data_d  = src_data;
    end
  end

  // Stage registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_nxt = valid_d;
  assign valid     = valid_q;
  assign data      = data_q;

endmodule

// File: rtl/logic_op_pipe.sv
// Elastic DEPTH-stage pipeline computing a bitwise op of x and y, with valid/ready,
// synchronous flush and a registered occupancy count.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_x,
  input  logic [WIDTH-1:0]           in_y,
  input  logic [1:0]                 in_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_z,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_valid_nxt;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [WIDTH-1:0] src_data   [DEPTH];
  logic [WIDTH-1:0] op_res;
  logic             accept;
  logic [OCC_W-1:0] occ_q, occ_d;

  // Ready chain: the recursive adv_i = !valid_i || adv_{i+1} is unrolled into
  // "some stage from i to the tail is empty, or the output is being taken".
  always_comb begin
    logic full_tail;
    full_tail = 1'b1;
    adv       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      full_tail = 1'b1;
      for (int unsigned j = i; j < DEPTH; j++) begin
        full_tail = full_tail & stage_valid[j];
      end
      adv[i] = !full_tail || out_ready;
    end
  end

  // Input acceptance, op evaluation at stage 0 and the per-stage upstream sources.
  always_comb begin
    in_ready    = reset && adv[0] && !flush;
    accept      = in_valid && in_ready;
    op_res      = WIDTH'(apply_op(op_t'(in_op), OP_MAX_W'(in_x), OP_MAX_W'(in_y)));
    src_valid   = '0;
    src_valid[0] = accept;
    src_data[0]  = op_res;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      src_valid[i] = stage_valid[i-1];
      src_data[i]  = stage_data[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic_op_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .adv       (adv[g]),
      .src_valid (src_valid[g]),
      .src_data  (src_data[g]),
      .valid_nxt (stage_valid_nxt[g]),
      .valid     (stage_valid[g]),
      .data      (stage_data[g])
    );
  end

  // Occupancy is the popcount of the stage valid bits the stages are about to load.
  always_comb begin
    occ_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(stage_valid_nxt[i]);
    end
  end

  // Occupancy register, updated alongside the stages.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign out_valid = stage_valid[DEPTH-1];
  assign out_z     = out_valid ? stage_data[DEPTH-1] : '0;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench for logic_op_pipe across several WIDTH/DEPTH configurations.
module tb_logic_op_pipe;

  int checks   = 0;
  int failures = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input int cfg, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL cfg%0d %s actual=%0h required=%0h", cfg, name, act, exp);
    end
  endtask

  for (genvar c = 0; c < 4; c++) begin : g_cfg
    localparam int unsigned W  = (c == 0) ? 8 : (c == 1) ? 8 : (c == 2) ? 1 : 32;
    localparam int unsigned D  = (c == 0) ? 2 : (c == 1) ? 4 : (c == 2) ? 1 : 8;
    localparam int unsigned OW = $clog2(D + 1);

    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic [W-1:0]  in_y;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_z;
    logic [OW-1:0] occupancy;

    logic [W-1:0]  sb_q [$];
    int unsigned   occ_snap = 0;
    int            acc_last = 0;
    logic          done = 1'b0;

    logic_op_pipe #(
      .WIDTH (W),
      .DEPTH (D)
    ) dut (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_z     (out_z),
      .occupancy (occupancy)
    );

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
        2'd0:    return a & b;
        2'd1:    return a | b;
        2'd2:    return a ^ b;
        default: return ~(a & b);
      endcase
    endfunction

    // One clock: check in_ready and record acceptance before the edge, then account for
    // flush and compare occupancy with the number of outstanding results after it.
    task automatic step();
      @(negedge clock);
      chk(c, "in_ready", 64'(in_ready), 64'(reset && !flush && (occ_snap < D || out_ready)));
      acc_last = (in_valid && in_ready) ? 1 : 0;
      if (in_valid && in_ready) sb_q.push_back(ref_op(in_op, in_x, in_y));
      @(posedge clock);
      #1;
      if (flush) sb_q.delete();
      chk(c, "occupancy", 64'(occupancy), 64'(sb_q.size()));
      occ_snap = sb_q.size();
    endtask

    task automatic drive_rand();
      in_valid = 1'b1;
      in_x     = W'($urandom);
      in_y     = W'($urandom);
      in_op    = 2'($urandom);
    endtask

    // Monitor: pops on every output handshake, checks held data under stall and output gating.
    initial begin : monitor
      logic         stall_prev;
      logic         flush_prev;
      logic [W-1:0] z_prev;
      stall_prev = 1'b0;
      flush_prev = 1'b0;
      z_prev     = '0;
      forever begin
        @(negedge clock);
        if (reset) begin
          if (stall_prev && !flush_prev) begin
            chk(c, "stall_hold_valid", 64'(out_valid), 64'(1));
            chk(c, "stall_hold_z", 64'(out_z), 64'(z_prev));
          end
          if (!out_valid) chk(c, "idle_z_zero", 64'(out_z), 64'(0));
          if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL cfg%0d unexpected_output actual=%0h required=none", c, out_z);
            end else begin
              chk(c, "out_z", 64'(out_z), 64'(sb_q.pop_front()));
            end
          end
          stall_prev = out_valid && !out_ready;
          flush_prev = flush;
          z_prev     = out_z;
        end else begin
          stall_prev = 1'b0;
        end
      end
    end

    initial begin : driver
      int n_acc;
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_x      = '0;
      in_y      = '0;
      in_op     = 2'd0;
      out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk(c, "rst_out_valid", 64'(out_valid), 64'(0));
      chk(c, "rst_out_z", 64'(out_z), 64'(0));
      chk(c, "rst_occupancy", 64'(occupancy), 64'(0));
      chk(c, "rst_in_ready", 64'(in_ready), 64'(0));
      reset = 1'b1;
      #1;
      chk(c, "in_ready_after_reset", 64'(in_ready), 64'(1));

      // Reset in the middle of traffic, then the first new item's latency.
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        drive_rand();
        step();
      end
      in_valid = 1'b0;
      reset    = 1'b0;
      sb_q.delete();
      occ_snap = 0;
      #1;
      chk(c, "async_rst_valid", 64'(out_valid), 64'(0));
      chk(c, "async_rst_z", 64'(out_z), 64'(0));
      chk(c, "async_rst_occ", 64'(occupancy), 64'(0));
      chk(c, "async_rst_in_ready", 64'(in_ready), 64'(0));
      #1;
      reset    = 1'b1;
      in_valid = 1'b1;
      in_x     = W'(32'hF0);
      in_y     = W'(32'h3C);
      in_op    = 2'd0;
      for (int k = 1; k <= int'(D); k++) begin
        step();
        in_valid = 1'b0;
        chk(c, "latency_valid", 64'(out_valid), 64'(k == int'(D)));
        if (k == int'(D)) chk(c, "latency_z", 64'(out_z), 64'(W'(32'h30)));
      end
      step();

      // All four ops back to back on the same operands.
      for (int k = 0; k < int'(D) + 4; k++) begin
        if (k < 4) begin
          in_valid = 1'b1;
          in_x     = W'(32'hF0);
          in_y     = W'(32'h3C);
          in_op    = 2'(k);
        end else begin
          in_valid = 1'b0;
        end
        step();
        chk(c, "opcov_valid", 64'(out_valid), 64'((k + 1 >= int'(D)) && (k + 1 <= int'(D) + 3)));
      end

      // Back-pressure: only D of D+2 offers fit, then drain.
      out_ready = 1'b0;
      n_acc     = 0;
      for (int k = 0; k < int'(D) + 2; k++) begin
        drive_rand();
        step();
        n_acc += acc_last;
      end
      chk(c, "bp_accepted", 64'(n_acc), 64'(D));
      chk(c, "bp_in_ready", 64'(in_ready), 64'(0));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (D + 1) step();
      chk(c, "bp_drained", 64'(occupancy), 64'(0));

      // Bubble collapse: B joins A while A is stalled at the output.
      if (D >= 2) begin
        drive_rand();
        step();
        in_valid = 1'b0;
        repeat (D - 1) step();
        chk(c, "bubble_a_out", 64'(out_valid), 64'(1));
        out_ready = 1'b0;
        drive_rand();
        step();
        in_valid = 1'b0;
        repeat (D) step();
        chk(c, "bubble_occ", 64'(occupancy), 64'(2));
        out_ready = 1'b1;
        step();
        chk(c, "bubble_b_next", 64'(out_valid), 64'(1));
        step();
        chk(c, "bubble_empty", 64'(out_valid), 64'(0));
      end

      // Flush a full pipeline with an input offered in the flush cycle.
      out_ready = 1'b0;
      n_acc     = 0;
      for (int k = 0; k < int'(D) + 1; k++) begin
        drive_rand();
        step();
        n_acc += acc_last;
      end
      chk(c, "flush_fill", 64'(n_acc), 64'(D));
      flush = 1'b1;
      drive_rand();
      #1;
      chk(c, "flush_in_ready", 64'(in_ready), 64'(0));
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk(c, "flush_occ", 64'(occupancy), 64'(0));
      chk(c, "flush_valid", 64'(out_valid), 64'(0));
      out_ready = 1'b1;
      drive_rand();
      for (int k = 1; k <= int'(D); k++) begin
        step();
        in_valid = 1'b0;
        chk(c, "post_flush_latency", 64'(out_valid), 64'(k == int'(D)));
      end
      step();

      // Random traffic with occasional flushes.
      n_acc = 0;
      for (int cyc = 0; cyc < 20000 && n_acc < 1000; cyc++) begin
        drive_rand();
        in_valid  = ($urandom_range(0, 1) == 1);
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 99) == 0);
        step();
        n_acc += acc_last;
      end
      chk(c, "rand_accepted", 64'(n_acc), 64'(1000));
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (D + 1) step();
      chk(c, "final_occ", 64'(occupancy), 64'(0));
      done = 1'b1;
    end
  end

  initial begin : watchdog
    int unsigned cyc;
    cyc = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done) && cyc < 60000) begin
      @(posedge clock);
      cyc++;
    end
    if (cyc >= 60000) begin
      checks++;
      failures++;
      $display("FAIL watchdog actual=timeout required=all_configs_done");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_op_pipe.md
Name: logic_op_pipe

Overview:
- Parametrised successor to the PD0 single-bit AND exercises: a WIDTH-bit, DEPTH-stage elastic pipeline that computes a per-transaction bitwise op of x and y.
- Valid/ready handshake on both sides, back-pressure stall, synchronous flush, occupancy count.
- Instantiated under core as the generic registered-logic datapath probed by the PD-level testbenches.

Parameters:
- WIDTH, 8, bit width of x, y, z.
- DEPTH, 2, number of register stages between input and output; legal range 1..8.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- flush  in  1  synchronous clear of all in-flight transactions.
- in_valid  in  1  input transaction present.
- in_ready  out  1  pipeline accepts input this cycle.
- in_x  in  WIDTH  operand x.
- in_y  in  WIDTH  operand y.
- in_op  in  2  operation select (see package encodings).
- out_valid  out  1  result present at output.
- out_ready  in  1  downstream accepts result.
- out_z  out  WIDTH  result.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset (reset == 0, asynchronous): all stage valid bits 0, all stage data 0. out_valid = 0, out_z = 0, occupancy = 0. in_ready = 0 while reset is asserted. After reset is released, in_ready = 1 from the next evaluation.
- Op encoding: 00 AND, 01 OR, 10 XOR, 11 NAND. The op is evaluated combinationally at stage 0 input and the result is registered. Later stages carry only the result, not the op.
- Stage i holds (valid_i, data_i). Stage DEPTH-1 drives out_valid and out_z.
- Advance rule:
  - adv_{DEPTH-1} = !valid_{DEPTH-1} || out_ready.
  - adv_i = !valid_i || adv_{i+1}.
  - in_ready = adv_0 && !flush.
  - The ready chain is combinational; there is no skid buffer.
- Stage update when adv_i: valid_i <= valid_{i-1}, data_i <= data_{i-1}. For stage 0, the source is in_valid && in_ready and op(in_x, in_y). When not adv_i, the stage holds.
- Transfer: input accepted when in_valid && in_ready. Output consumed when out_valid && out_ready.
- Latency: exactly DEPTH cycles from acceptance to out_valid with out_ready held 1. Throughput is 1 transaction per cycle.
- Stall: while out_valid && !out_ready, out_z is held stable. Bubbles upstream may collapse. Once full, in_ready = 0.
- Data of invalid stages: don't-care internally, but out_z = 0 whenever out_valid = 0 (gated at output).
- Flush: on a clock edge with flush = 1, all valid bits clear and the input is not accepted. An out_valid && out_ready handshake visible in the flush cycle counts as consumed. Flush has priority over every advance.
- occupancy = popcount of stage valid bits, registered alongside the stages. Range 0..DEPTH, never exceeds DEPTH.
- Ordering: results leave strictly in acceptance order; there is no drop or duplication except by flush.
- No X propagation: every register has a reset value, and all outputs are defined immediately after reset.

Decomposition:
- Package logic_op_pkg:
  - op_t (2-bit enum OP_AND, OP_OR, OP_XOR, OP_NAND).
  - function apply_op(op_t, x, y), parametrised by width through the caller's slicing.
- Sub-module logic_op_stage (one valid+data register with adv, flush and async active-low reset), generated DEPTH times.
- occupancy is computed in the top level.

Test Plan:
- Reset mid-traffic: with DEPTH = 2, stream 3 transactions, then assert reset low for one half-cycle. Required: out_valid = 0, out_z = 0, occupancy = 0 asynchronously (before the next edge). After release, the first new input x = 8'hF0, y = 8'h3C, AND yields z = 8'h30 after exactly 2 cycles.
- Op coverage: x = 8'hF0, y = 8'h3C with ops 00/01/10/11 back-to-back, out_ready = 1. Required: z = 30, FC, CC, CF on 4 consecutive cycles starting at cycle 2.
- Back-pressure: with DEPTH = 2, hold out_ready = 0 and offer 4 transactions. Required:
  - exactly 2 are accepted, then in_ready = 0 and occupancy = 2;
  - out_z stays stable;
  - after releasing out_ready, the remaining transactions drain in order with no loss.
- Bubble collapse: accept A, idle 1 cycle, accept B with out_ready = 0 while A is at the output. Required: B advances to stage 0 → stage 1 behind A, occupancy = 2, then A and B emerge on consecutive cycles after out_ready = 1.
- Flush: with DEPTH = 4 full and in_valid = 1 during the flush cycle. Required:
  - occupancy = 0 and out_valid = 0 after the edge;
  - the input is not accepted (in_ready = 0 during flush);
  - the next accepted item appears after 4 cycles.
- Width/depth sweep: run WIDTH ∈ {1, 32}, DEPTH ∈ {1, 8} with random ops, random in_valid and out_ready, against a scoreboard queue. Required: zero mismatches over 1000 transactions, and occupancy always equals the queue depth.
